// File: rtl/tx_r2m_pkg.sv
// tx_r2m_pkg
// Shared definitions for the router-to-MAC packet bridge:
//   - r2m_state_t : packet FSM state encoding
//   - sop_pos()   : bit index of SOP inside a flit of the given widths
//   - eop_pos()   : bit index of EOP inside a flit of the given widths
// Flit layout: {SOP, EOP, data[DATA_W-1:0], valid[VLD_W-1:0]}.
package tx_r2m_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PKT  = 2'd1,
        ST_GAP  = 2'd2
    } r2m_state_t;

    function automatic int sop_pos(input int data_w, input int vld_w);
        return data_w + vld_w + 1;
    endfunction

    function automatic int eop_pos(input int data_w, input int vld_w);
        return data_w + vld_w;
    endfunction

endpackage

// File: rtl/tx_r2m_fifo.sv
// tx_r2m_fifo
// Skid FIFO between the router interface and the MAC output stage.
// Head word is presented combinationally on o_rdata while not empty.
// Ports:
//   clk, rst_n        clock, async active-low reset (flushes pointers)
//   i_wr, i_wdata     push request and data
//   i_rd              pop request (head consumed)
//   o_rdata           head word
//   o_full, o_empty   status flags; o_full is a flop
module tx_r2m_fifo #(
    parameter int WIDTH = 70,
    parameter int DEPTH = 4
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             r_full;
    logic [AW:0]      w_count_nxt;
    logic             w_wr;
    logic             w_rd;

    // A push while full is legal when the head leaves on the same edge.
    assign w_wr = i_wr && (!r_full || i_rd);
    assign w_rd = i_rd && (r_count != '0);

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr && !w_rd) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_wr && w_rd) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    // Full is held high during reset so the upstream ack stays low until
    // the first clock edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b1;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == FULL_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_full  = r_full;
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/tx_router2mac_pkt.sv
// tx_router2mac_pkt
// Bridges router flits to a MAC word interface: skid FIFO, packet FSM,
// registered output stage, inter-packet gap insertion and protocol checks.
// Optional feature macro: TX_R2M_PKT_CNT_EN (enables the packet counter;
// without it pkt_cnt is tied to zero).
// Ports:
//   clk, rst_n            clock, async active-low reset
//   data_router, val, ack flit input handshake (ack is a flop)
//   data_mac, valid_mac   MAC data and byte-valid count
//   sop_mac, eop_mac      packet delimiters
//   mac_val, mac_rdy      MAC output handshake
//   err                   one-cycle protocol error pulse
//   pkt_cnt               completed packet count
//
// state   | meaning
// IDLE    | waiting for a SOP flit; non-SOP heads are dropped with err
// PKT     | forwarding body flits until EOP
// GAP     | EOP issued; after it is accepted, hold mac_val low IPG cycles
module tx_router2mac_pkt
    import tx_r2m_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int VLD_W  = 4,
    parameter int DEPTH  = 4,
    parameter int IPG    = 3,
    localparam int FLIT_W = DATA_W + VLD_W + 2
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLIT_W-1:0] data_router,
    input  logic              val,
    output logic              ack,
    output logic [DATA_W-1:0] data_mac,
    output logic [VLD_W-1:0]  valid_mac,
    output logic              sop_mac,
    output logic              eop_mac,
    output logic              mac_val,
    input  logic              mac_rdy,
    output logic              err,
    output logic [31:0]       pkt_cnt
);
    localparam int SOP_B = sop_pos(DATA_W, VLD_W);
    localparam int EOP_B = eop_pos(DATA_W, VLD_W);
    localparam logic [3:0] GAP_LOAD = (IPG > 0) ? 4'(IPG - 1) : 4'd0;
    localparam r2m_state_t ST_AFTER_EOP = (IPG > 0) ? ST_GAP : ST_IDLE;

    logic [FLIT_W-1:0] w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_free;
    logic              w_take;
    logic              w_start;
    logic              w_h_sop;
    logic              w_h_eop;
    logic [DATA_W-1:0] w_h_data;
    logic [VLD_W-1:0]  w_h_vld;

    r2m_state_t        r_state;
    logic [3:0]        r_gap;
    logic [DATA_W-1:0] r_data;
    logic [VLD_W-1:0]  r_vld;
    logic              r_sop;
    logic              r_eop;
    logic              r_mac_val;
    logic              r_err;

    assign ack    = !w_full;
    assign w_push = val && ack;

    tx_r2m_fifo #(
        .WIDTH (FLIT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_wr    (w_push),
        .i_wdata (data_router),
        .i_rd    (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_h_sop  = w_head[SOP_B];
    assign w_h_eop  = w_head[EOP_B];
    assign w_h_data = w_head[VLD_W +: DATA_W];
    assign w_h_vld  = w_head[VLD_W-1:0];

    assign w_free = !r_mac_val || mac_rdy;
    assign w_take = r_mac_val && mac_rdy;
    // The last gap cycle behaves as IDLE so the next SOP can load on the
    // edge that ends the gap, giving exactly IPG empty cycles.
    assign w_start = (r_state == ST_IDLE) ||
                     ((r_state == ST_GAP) && !r_mac_val && (r_gap == 4'd0));
    assign w_pop   = !w_empty && w_free && (w_start || (r_state == ST_PKT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_gap     <= 4'd0;
            r_data    <= '0;
            r_vld     <= '0;
            r_sop     <= 1'b0;
            r_eop     <= 1'b0;
            r_mac_val <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_err <= 1'b0;

            // Consumed word leaves the stage; zeroed fields keep the
            // outputs clean while mac_val is low.
            if (w_take) begin
                r_mac_val <= 1'b0;
                r_data    <= '0;
                r_vld     <= '0;
                r_sop     <= 1'b0;
                r_eop     <= 1'b0;
            end

            if (w_pop) begin
                if (r_state == ST_PKT) begin
                    r_mac_val <= 1'b1;
                    r_data    <= w_h_data;
                    r_vld     <= w_h_vld;
                    r_sop     <= 1'b0;
                    r_eop     <= w_h_eop;
                    r_err     <= w_h_sop;
                    if (w_h_eop) r_state <= ST_AFTER_EOP;
                end else if (w_h_sop) begin
                    r_mac_val <= 1'b1;
                    r_data    <= w_h_data;
                    r_vld     <= w_h_vld;
                    r_sop     <= 1'b1;
                    r_eop     <= w_h_eop;
                    r_state   <= w_h_eop ? ST_AFTER_EOP : ST_PKT;
                end else begin
                    r_err   <= 1'b1;
                    r_state <= ST_IDLE;
                end
            end else if (w_start && (r_state == ST_GAP)) begin
                r_state <= ST_IDLE;
            end

            // Gap down-counter: loaded when the EOP word is accepted.
            if (r_state == ST_GAP) begin
                if (w_take) begin
                    r_gap <= GAP_LOAD;
                end else if (!r_mac_val && (r_gap != 4'd0)) begin
                    r_gap <= r_gap - 4'd1;
                end
            end
        end
    end

    assign data_mac  = r_data;
    assign valid_mac = r_vld;
    assign sop_mac   = r_sop;
    assign eop_mac   = r_eop;
    assign mac_val   = r_mac_val;
    assign err       = r_err;

`ifdef TX_R2M_PKT_CNT_EN
    logic [31:0] r_pkt_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pkt_cnt <= 32'd0;
        end else if (w_take && r_eop) begin
            r_pkt_cnt <= r_pkt_cnt + 32'd1;
        end
    end

    assign pkt_cnt = r_pkt_cnt;
`else
    assign pkt_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_tx_router2mac_pkt.sv
// tb_tx_router2mac_pkt
// Directed scenarios plus randomized packet traffic for tx_router2mac_pkt.
// Expected MAC words come from a packet-level reference queue built from
// the accepted flits; a second instance with IPG=0 covers back-to-back
// packets.
module tb_tx_router2mac_pkt;
    localparam int DW   = 64;
    localparam int VW   = 4;
    localparam int DEP  = 4;
    localparam int IPGV = 3;
    localparam int FW   = DW + VW + 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [FW-1:0] data_router;
    logic          val;
    logic          ack;
    logic [DW-1:0] data_mac;
    logic [VW-1:0] valid_mac;
    logic          sop_mac, eop_mac, mac_val, mac_rdy, err;
    logic [31:0]   pkt_cnt;

    logic [FW-1:0] data0;
    logic          val0, ack0;
    logic [DW-1:0] data_mac0;
    logic [VW-1:0] valid_mac0;
    logic          sop0, eop0, mac_val0, rdy0, err0;
    logic [31:0]   pkt_cnt0;

    tx_router2mac_pkt #(.DATA_W(DW), .VLD_W(VW), .DEPTH(DEP), .IPG(IPGV)) u_dut (
        .clk(clk), .rst_n(rst_n), .data_router(data_router), .val(val), .ack(ack),
        .data_mac(data_mac), .valid_mac(valid_mac), .sop_mac(sop_mac), .eop_mac(eop_mac),
        .mac_val(mac_val), .mac_rdy(mac_rdy), .err(err), .pkt_cnt(pkt_cnt));

    tx_router2mac_pkt #(.DATA_W(DW), .VLD_W(VW), .DEPTH(DEP), .IPG(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .data_router(data0), .val(val0), .ack(ack0),
        .data_mac(data_mac0), .valid_mac(valid_mac0), .sop_mac(sop0), .eop_mac(eop0),
        .mac_val(mac_val0), .mac_rdy(rdy0), .err(err0), .pkt_cnt(pkt_cnt0));

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: expected words {sop, eop, valid, data}
    logic [FW-1:0] exp_q[$];
    bit            m_in_pkt;
    int            exp_err, err_seen, exp_pkts;
    int            cyc, acc_edge, n_acc, n_take;
    int            sop_take_cyc, eop_take_cyc, gap_run, last_gap;
    logic [VW-1:0] last_eop_vld;
    logic [1:0]    last_se;
    bit            after_eop, prev_hold, rdy_rand;
    logic [FW-1:0] prev_word, mw;

    task automatic model_push(input bit sop, input bit eop, input logic [DW-1:0] d,
                              input logic [VW-1:0] v);
        if (!m_in_pkt) begin
            if (sop) begin
                exp_q.push_back({1'b1, eop, v, d});
                m_in_pkt = !eop;
            end else begin
                exp_err++;
            end
        end else begin
            if (sop) exp_err++;
            exp_q.push_back({1'b0, eop, v, d});
            if (eop) m_in_pkt = 1'b0;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_in_pkt  = 1'b0;
        exp_err   = 0;
        err_seen  = 0;
        exp_pkts  = 0;
        after_eop = 1'b0;
        prev_hold = 1'b0;
    endtask

    function automatic logic [31:0] exp_cnt();
`ifdef TX_R2M_PKT_CNT_EN
        return 32'(exp_pkts);
`else
        return 32'd0;
`endif
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input bit sop, input bit eop, input logic [DW-1:0] d,
                        input logic [VW-1:0] v);
        bit done = 1'b0;
        data_router = {sop, eop, d, v};
        val = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            if (ack) begin
                model_push(sop, eop, d, v);
                n_acc++;
                acc_edge = cyc + 1;
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        val = 1'b0;
        chk("send_accepted", done, 1);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 400 && exp_q.size() != 0; t++) begin
            @(posedge clk); #1;
        end
        chk("drain_left", exp_q.size(), 0);
        cycles(IPGV + 4);
    endtask

    initial begin
        cyc = 0;
        forever begin @(posedge clk); cyc++; end
    end

    initial begin
        rdy_rand = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rdy_rand) mac_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (err) err_seen++;
            if (prev_hold)
                chk("hold_stable", {mac_val, sop_mac, eop_mac, valid_mac, data_mac}, {1'b1, prev_word});
            if (mac_val) begin
                if (after_eop) begin
                    last_gap = gap_run;
                    chk("ipg_min", (gap_run >= IPGV), 1);
                    after_eop = 1'b0;
                end
                if (mac_rdy) begin
                    n_take++;
                    chk("exp_avail", (exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        mw = exp_q.pop_front();
                        chk("word", {sop_mac, eop_mac, valid_mac, data_mac}, mw);
                        if (mw[FW-2]) exp_pkts++;
                    end
                    last_se = {sop_mac, eop_mac};
                    if (sop_mac) sop_take_cyc = cyc;
                    if (eop_mac) begin
                        eop_take_cyc = cyc;
                        after_eop    = 1'b1;
                        gap_run      = 0;
                        last_eop_vld = valid_mac;
                    end
                end
                prev_hold = !mac_rdy;
                prev_word = {sop_mac, eop_mac, valid_mac, data_mac};
            end else begin
                chk("idle_zero", {sop_mac, eop_mac, valid_mac, data_mac}, 0);
                if (after_eop) gap_run++;
                prev_hold = 1'b0;
            end
        end
    end

    int         n0, first0, last0;
    logic [3:0] sop_seq0, eop_seq0;

    always @(negedge clk) begin
        if (rst_n && mac_val0) begin
            if (n0 == 0) first0 = cyc;
            last0    = cyc;
            sop_seq0 = {sop_seq0[2:0], sop0};
            eop_seq0 = {eop_seq0[2:0], eop0};
            n0++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", n_err);
        $fatal(1);
    end

    int a0, t1_sop, e0, tk0;

    initial begin
        rst_n = 1'b0; val = 1'b0; data_router = '0; mac_rdy = 1'b1;
        val0 = 1'b0; data0 = '0; rdy0 = 1'b1;
        n0 = 0; sop_seq0 = '0; eop_seq0 = '0;
        n_acc = 0; n_take = 0; gap_run = 0; last_gap = 0;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", {ack, mac_val, sop_mac, eop_mac, valid_mac, data_mac, err, pkt_cnt}, 0);
        rst_n = 1'b1;
        #1;
        chk("ack_before_edge", ack, 0);
        cycles(1);
        chk("ack_after_edge", ack, 1);
        cycles(1);

        // Three-flit packet followed directly by a single-flit packet
        send(1'b1, 1'b0, {8{8'h11}}, 4'd8);
        a0 = acc_edge;
        send(1'b0, 1'b0, {8{8'h22}}, 4'd8);
        send(1'b0, 1'b1, {8{8'h33}}, 4'd5);
        t1_sop = sop_take_cyc;
        chk("first_latency", t1_sop - a0, 1);
        send(1'b1, 1'b1, {8{8'h44}}, 4'd7);
        cycles(1);
        chk("eop_consecutive", eop_take_cyc - t1_sop, 2);
        chk("eop_valid", last_eop_vld, 5);
        cycles(10);
        chk("gap_exact", last_gap, IPGV);
        chk("single_sop_eop", last_se, 2'b11);
        chk("pkt_cnt_a", pkt_cnt, exp_cnt());
        wait_drain();

        // Backpressure: 8-flit packet with MAC stalled for 10 cycles
        mac_rdy = 1'b0;
        n_acc = 0;
        fork
            begin
                send(1'b1, 1'b0, {$urandom, $urandom}, 4'd8);
                for (int i = 0; i < 6; i++) send(1'b0, 1'b0, {$urandom, $urandom}, 4'd8);
                send(1'b0, 1'b1, {$urandom, $urandom}, 4'd3);
            end
            begin
                repeat (10) @(posedge clk);
                #2;
                chk("stall_accepts", n_acc, DEP + 1);
                chk("stall_ack", ack, 0);
                mac_rdy = 1'b1;
            end
        join
        wait_drain();

        // Stray non-SOP flit in IDLE, then a normal packet
        e0 = err_seen; tk0 = n_take;
        send(1'b0, 1'b1, {8{8'hEE}}, 4'd2);
        cycles(6);
        chk("stray_err_pulse", err_seen - e0, 1);
        chk("stray_no_word", n_take - tk0, 0);
        send(1'b1, 1'b0, {8{8'h55}}, 4'd8);
        send(1'b0, 1'b1, {8{8'h66}}, 4'd1);
        wait_drain();
        chk("err_total_a", err_seen, exp_err);

        // Reset in mid-packet with the SOP word held at the output
        mac_rdy = 1'b0;
        send(1'b1, 1'b0, {8{8'h77}}, 4'd8);
        send(1'b0, 1'b0, {8{8'h88}}, 4'd8);
        cycles(2);
        chk("held_before_rst", {mac_val, sop_mac}, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_outs", {ack, mac_val, sop_mac, eop_mac, valid_mac, data_mac, err, pkt_cnt}, 0);
        chk("rst_fifo_empty", u_dut.w_empty, 1);
        model_reset();
        cycles(2);
        rst_n = 1'b1;
        #1;
        chk("ack_before_edge2", ack, 0);
        cycles(1);
        chk("ack_after_edge2", ack, 1);
        mac_rdy = 1'b1;
        send(1'b1, 1'b0, {8{8'h99}}, 4'd8);
        send(1'b0, 1'b1, {8{8'hAA}}, 4'd4);
        wait_drain();

        // Randomized traffic with random MAC backpressure
        rdy_rand = 1'b1;
        for (int p = 0; p < 40; p++) begin
            if ($urandom_range(0, 9) == 0)
                send(1'b0, 1'($urandom_range(0, 1)), {$urandom, $urandom}, 4'($urandom_range(1, 8)));
            begin
                int len = $urandom_range(1, 4);
                for (int i = 0; i < len; i++) begin
                    send((i == 0) || ($urandom_range(0, 11) == 0), (i == len - 1),
                         {$urandom, $urandom}, 4'($urandom_range(1, 8)));
                end
            end
            if ($urandom_range(0, 3) == 0) cycles($urandom_range(1, 5));
        end
        rdy_rand = 1'b0;
        cycles(1);
        mac_rdy = 1'b1;
        wait_drain();
        chk("err_total_rand", err_seen, exp_err);
        chk("pkt_cnt_rand", pkt_cnt, exp_cnt());

        // Back-to-back packets on the IPG=0 instance
        chk("ack0_ready", ack0, 1);
        val0 = 1'b1;
        data0 = {1'b1, 1'b1, {8{8'hA1}}, 4'd8}; cycles(1);
        data0 = {1'b1, 1'b1, {8{8'hB2}}, 4'd8}; cycles(1);
        data0 = {1'b1, 1'b0, {8{8'hC3}}, 4'd8}; cycles(1);
        data0 = {1'b0, 1'b1, {8{8'hD4}}, 4'd6}; cycles(1);
        val0 = 1'b0;
        cycles(6);
        chk("ipg0_words", n0, 4);
        chk("ipg0_span", last0 - first0, 3);
        chk("ipg0_sop_seq", sop_seq0, 4'b1110);
        chk("ipg0_eop_seq", eop_seq0, 4'b1101);
        chk("ipg0_no_err", err0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/tx_router2mac_pkt.md
TX_ROUTER2MAC_PKT -- requirements
Module: tx_router2mac_pkt

Interface
REQ-001 SHALL have parameter DATA_W, default 64: MAC data width in bits, multiple of 8.
REQ-002 SHALL have parameter VLD_W, default 4: byte-valid count field width.
REQ-003 SHALL have parameter DEPTH, default 4: skid FIFO depth in flits, power of 2, minimum 2.
REQ-004 SHALL have parameter IPG, default 3: idle cycles inserted after each EOP, range 0..15.
REQ-005 SHALL define FLIT_W = DATA_W+VLD_W+2, with flit layout [FLIT_W-1]=SOP, [FLIT_W-2]=EOP, [VLD_W+DATA_W-1:VLD_W]=data, [VLD_W-1:0]=valid.
REQ-006 SHALL have port: clk  in  1  single clock, all logic on rising edge.
REQ-007 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have port: data_router  in  FLIT_W  flit from router.
REQ-009 SHALL have port: val  in  1  data_router valid.
REQ-010 SHALL have port: ack  out  1  flit accepted when val&&ack.
REQ-011 SHALL have port: data_mac  out  DATA_W  data to MAC.
REQ-012 SHALL have port: valid_mac  out  VLD_W  byte-valid field to MAC.
REQ-013 SHALL have port: sop_mac, eop_mac  out  1 each  packet delimiters to MAC.
REQ-014 SHALL have port: mac_val  out  1  output word valid.
REQ-015 SHALL have port: mac_rdy  in  1  MAC accepts word when mac_val&&mac_rdy.
REQ-016 SHALL have port: err  out  1  one-cycle protocol-error pulse.
REQ-017 SHALL have port: pkt_cnt  out  32  completed-packet count.

Function
REQ-018 SHALL assert ack = FIFO not full; ack SHALL be driven from registers only, with no combinational path from val.
REQ-019 SHALL write the flit into the FIFO on each val&&ack edge; simultaneous push and pop SHALL be permitted when full.
REQ-020 SHALL contain a registered output stage; the first word SHALL appear on mac_val two edges after acceptance (FIFO write, then output load).
REQ-021 SHALL hold data_mac, valid_mac, sop_mac, eop_mac and mac_val stable while mac_val=1 and mac_rdy=0.
REQ-022 SHALL implement FSM states IDLE, PKT and GAP.
REQ-023 In IDLE with FIFO head SOP=1, the FSM SHALL load the output with sop_mac=1 and go to PKT; if the head also has EOP=1, it SHALL go to GAP, or to IDLE when IPG=0.
REQ-024 In IDLE with FIFO head SOP=0, the FSM SHALL pop and discard the flit, pulse err and stay in IDLE.
REQ-025 In PKT, the block SHALL forward the head each time the output stage is empty or being consumed; a flit with EOP=1 SHALL go to GAP (IPG>0) or IDLE (IPG=0) once accepted by the MAC.
REQ-026 In PKT, a head flit with SOP=1 SHALL pulse err and be forwarded with sop_mac=0.
REQ-027 GAP SHALL hold mac_val=0 for exactly IPG cycles, counted from the edge after the EOP word is accepted, then return to IDLE.
REQ-028 valid_mac SHALL pass the flit valid field unchanged; data and valid SHALL not be modified.
REQ-029 When the output stage is not valid, data_mac, valid_mac, sop_mac and eop_mac SHALL be 0.

Reset
REQ-030 On rst_n=0, all outputs SHALL go to 0 immediately, the FIFO SHALL be flushed, the FSM SHALL enter IDLE and the GAP counter SHALL clear.
REQ-031 Reset in mid-packet SHALL drop the partial packet with no eop_mac issued; ack SHALL rise on the first edge after deassertion.

Configuration
REQ-032 Macro TX_R2M_PKT_CNT_EN SHALL control the packet counter.
REQ-033 With the macro defined, pkt_cnt SHALL increment on each accepted eop_mac word and wrap from 2^32-1 to 0.
REQ-034 Without the macro, pkt_cnt SHALL be tied to 0 and no counter flops SHALL be synthesised; the port SHALL remain.

Structure
REQ-035 Package tx_r2m_pkg SHALL hold the FSM state encoding and the SOP/EOP bit-offset functions of DATA_W and VLD_W.
REQ-036 The FIFO SHALL be sub-module tx_r2m_fifo (parametrised width and depth, with full/empty flags); the FSM, output stage and counters SHALL be in the top module.

Verification
REQ-037 Reset then 3-flit packet (SOP, mid, EOP; data 0x11.., 0x22.., 0x33..; valid 8, 8, 5) with mac_rdy=1 -> 3 consecutive mac_val words, sop on the first, eop on the third with valid_mac=5, then 3 idle cycles.
REQ-038 Single flit with SOP=EOP=1 -> one word with sop_mac=eop_mac=1; pkt_cnt=1 (macro on) or 0 (macro off).
REQ-039 mac_rdy=0 for 10 cycles while streaming -> ack drops after DEPTH+1 flits, output held stable, no loss or reorder after release.
REQ-040 Flit with SOP=0 in IDLE -> err pulses for 1 cycle, no mac_val, next SOP packet forwarded normally.
REQ-041 rst_n low mid-packet after 2 of 4 flits -> outputs 0 asynchronously, FIFO empty, next packet starts with sop_mac.
REQ-042 Back-to-back packets with IPG=0 -> zero idle cycles between EOP and the next SOP.
